// File: rtl/gsim_forward.sv
// Forward banded 16x16 product b = A*x over a streamed Q16.16 vector, emitting rounded/saturated int16 b.
// Latency: b_i leaves two edges after x_{i+3} is accepted; busy for three flush cycles after x15, no backpressure.
module gsim_forward (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        out_valid,
  output logic        out_last,
  output logic [15:0] b_out
);

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] fcnt, fcnt_nxt;

  logic signed [31:0] win     [7];
  logic signed [31:0] win_nxt [7];
  logic win_vld, win_vld_nxt;
  logic win_last, win_last_nxt;

  logic signed [37:0] c0, p1, p2, p3;
  logic signed [37:0] acc_d, acc_q;
  logic               acc_vld, acc_last;

  logic signed [37:0] rnd;
  logic        [15:0] b_sat;

  function automatic logic signed [37:0] sx(input logic signed [31:0] v);
    sx = {{6{v[31]}}, v};
  endfunction

  // Window / sequencing: w6 receives new samples, w3 is the centre element.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    fcnt_nxt     = fcnt;
    win_vld_nxt  = 1'b0;
    win_last_nxt = 1'b0;
    for (int i = 0; i < 7; i++) win_nxt[i] = win[i];

    case (state)
      S_LOAD: begin
        if (cnt == 4'd0) begin
          // First edge of a vector clears the window; a sample on it becomes x0.
          for (int i = 0; i < 6; i++) win_nxt[i] = '0;
          win_nxt[6] = in_en ? x_in : '0;
        end else if (in_en) begin
          for (int i = 0; i < 6; i++) win_nxt[i] = win[i+1];
          win_nxt[6] = x_in;
        end
        if (in_en) begin
          cnt_nxt     = cnt + 4'd1;
          win_vld_nxt = (cnt >= 4'd3);
          if (cnt == 4'd15) begin
            state_nxt = S_FLUSH;
            fcnt_nxt  = 2'd0;
          end
        end
      end
      S_FLUSH: begin
        for (int i = 0; i < 6; i++) win_nxt[i] = win[i+1];
        win_nxt[6]  = '0;
        win_vld_nxt = 1'b1;
        fcnt_nxt    = fcnt + 2'd1;
        if (fcnt == 2'd2) begin
          win_last_nxt = 1'b1;
          state_nxt    = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOAD;
      cnt      <= 4'd0;
      fcnt     <= 2'd0;
      win_vld  <= 1'b0;
      win_last <= 1'b0;
      for (int i = 0; i < 7; i++) win[i] <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      fcnt     <= fcnt_nxt;
      win_vld  <= win_vld_nxt;
      win_last <= win_last_nxt;
      for (int i = 0; i < 7; i++) win[i] <= win_nxt[i];
    end
  end

  assign busy = (state == S_FLUSH);

  // 20*c - 13*p1 + 6*p2 - p3, all as shift-add; |sum| < 60*2^31 fits 38 bits.
  always_comb begin
    c0    = sx(win[3]);
    p1    = sx(win[2]) + sx(win[4]);
    p2    = sx(win[1]) + sx(win[5]);
    p3    = sx(win[0]) + sx(win[6]);
    acc_d = (c0 <<< 4) + (c0 <<< 2)
          - ((p1 <<< 3) + (p1 <<< 2) + p1)
          + (p2 <<< 2) + (p2 <<< 1)
          - p3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      acc_vld  <= 1'b0;
      acc_last <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      acc_vld  <= win_vld;
      acc_last <= win_last;
    end
  end

  // Round half toward +inf, then clamp to int16.
  always_comb begin
    rnd = (acc_q + 38'sd32768) >>> 16;
    if (rnd > 38'sd32767)
      b_sat = 16'h7FFF;
    else if (rnd < -38'sd32768)
      b_sat = 16'h8000;
    else
      b_sat = rnd[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      b_out     <= 16'd0;
    end else begin
      out_valid <= acc_vld;
      out_last  <= acc_vld & acc_last;
      if (acc_vld) b_out <= b_sat;
    end
  end

endmodule

// File: tb/tb_gsim_forward.sv
// Directed + randomized bench for gsim_forward against a direct matrix-product reference.
module tb_gsim_forward;

  logic        clk;
  logic        reset;
  logic        in_en;
  logic [31:0] x_in;
  logic        busy;
  logic        out_valid;
  logic        out_last;
  logic [15:0] b_out;

  gsim_forward dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_last  (out_last),
    .b_out     (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] b;
    logic        last;
    int          c;
  } cap_t;

  cap_t cap_q[$];
  cap_t cap_e;

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      cap_e.b    = b_out;
      cap_e.last = out_last;
      cap_e.c    = cyc;
      cap_q.push_back(cap_e);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] xv [11][16];
  int          ae [11][16];
  int          t_ones [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int coef(input int d);
    case (d < 0 ? -d : d)
      0:       return 20;
      1:       return -13;
      2:       return 6;
      3:       return -1;
      default: return 0;
    endcase
  endfunction

  // b_i = sum_j A[i][j] * x_j with real multiplies, then floor((s + 0.5) ) and clamp.
  function automatic logic [15:0] ref_b(input int v, input int i);
    longint s;
    int     j;
    s = 0;
    for (int d = -3; d <= 3; d++) begin
      j = i + d;
      if (j >= 0 && j < 16) s += longint'(coef(d)) * longint'($signed(xv[v][j]));
    end
    s = (s + 64'sd32768) >>> 16;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // mode 0: contiguous, 1: one idle cycle between samples, 2: random 0..2 idle cycles
  task automatic send_vec(input int v, input int mode);
    int ngap;
    for (int k = 0; k < 16; k++) begin
      ngap = 0;
      if (k > 0) ngap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (ngap) begin
        @(negedge clk);
        in_en = 1'b0;
        x_in  = $urandom;
      end
      @(negedge clk);
      if (k == 0) chk($sformatf("busy_idle_v%0d", v), {31'd0, busy}, 32'd0);
      in_en    = 1'b1;
      x_in     = xv[v][k];
      ae[v][k] = cyc + 1;
    end
  endtask

  task automatic flush_phase(input logic junk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("busy_flush%0d", k), {31'd0, busy}, 32'd1);
      in_en = junk;
      x_in  = $urandom;
    end
  endtask

  task automatic drain(input int need);
    int t;
    t = 0;
    @(negedge clk);
    in_en = 1'b0;
    while (cap_q.size() < need && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("drain_count", cap_q.size(), need);
  endtask

  task automatic check_vec(input int v);
    cap_t        c;
    logic [15:0] e;
    int          ecyc;
    for (int i = 0; i < 16; i++) begin
      if (cap_q.size() == 0) break;
      c = cap_q.pop_front();
      if (v == 0 || v == 1 || v == 10) e = t_ones[i][15:0];
      else                             e = ref_b(v, i);
      ecyc = (i <= 12) ? ae[v][i+3] + 2 : ae[v][15] + i - 10;
      chk($sformatf("val_v%0d_b%0d", v, i), {{16{c.b[15]}}, c.b}, {{16{e[15]}}, e});
      chk($sformatf("cyc_v%0d_b%0d", v, i), c.c, ecyc);
      chk($sformatf("last_v%0d_b%0d", v, i), {31'd0, c.last}, (i == 15) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_vld"},   {31'd0, out_valid}, 32'd0);
    chk({tag, "_last"},  {31'd0, out_last},  32'd0);
    chk({tag, "_b"},     {16'd0, b_out},     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    x_in  = 32'd0;

    for (int v = 0; v < 11; v++)
      for (int k = 0; k < 16; k++) begin
        case (v)
          0, 1, 10: xv[v][k] = 32'h0001_0000;
          2:        xv[v][k] = (k == 5) ? 32'h0001_0000 : 32'd0;
          3:        xv[v][k] = (k == 0) ? 32'h0000_0800 : 32'd0;
          4:        xv[v][k] = 32'h7FFF_0000;
          5:        xv[v][k] = (k == 5) ? 32'h8000_0000 : 32'd0;
          default:  xv[v][k] = $urandom;
        endcase
      end

    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Back-to-back: vector 0 contiguous, junk during its flush, vector 1 right after.
    send_vec(0, 0);
    flush_phase(1'b1);
    send_vec(1, 1);
    flush_phase(1'b0);
    for (int v = 2; v <= 5; v++) begin
      send_vec(v, 0);
      flush_phase(1'b0);
    end
    for (int v = 6; v <= 9; v++) begin
      send_vec(v, 2);
      flush_phase(1'b0);
    end
    drain(160);
    for (int v = 0; v <= 9; v++) check_vec(v);

    // Reset after eight accepted samples; nothing of that vector may surface afterwards.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_en = 1'b1;
      x_in  = 32'h0001_0000;
    end
    @(negedge clk);
    reset = 1'b1;
    in_en = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    cap_q.delete();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_stale", cap_q.size(), 0);

    send_vec(10, 0);
    flush_phase(1'b0);
    drain(16);
    check_vec(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gsim_forward.md
# gsim_forward

Forward-direction companion to the Gauss-Seidel solver. It accepts a 16-entry solution vector x, streamed as signed Q16.16 words. It applies the same banded 16x16 system matrix the solver inverts and returns the 16-entry right-hand side b as rounded, saturated 16-bit integers. It sits on the solver's output side: it reads `x_out`/`out_valid` and regenerates b, closing the loop for on-chip residual checking.

## Interface
- No parameters. Vector length is 16; matrix coefficients are 20 (diagonal), -13 (distance 1), +6 (distance 2), -1 (distance 3).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the sampled edge.
- in_en  in  1  x_in is valid this cycle; sampled at rising edge.
- x_in  in  32  signed Q16.16 element x_k; elements arrive in order k = 0..15.
- busy  out  1  flush in progress; in_en is ignored while high.
- out_valid  out  1  b_out holds b_i this cycle.
- out_last  out  1  high with out_valid for b_15 only.
- b_out  out  16  signed integer b_i; elements leave in order i = 0..15.

## Operation
- Relation computed: b_i = 20·x_i − 13(x_{i−1}+x_{i+1}) + 6(x_{i−2}+x_{i+2}) − (x_{i−3}+x_{i+3}). Any x index outside 0..15 is taken as zero.
- Window: a 7-deep shift register w0..w6 of 32-bit signed values, with w3 as the centre.
  - An accepted sample shifts in at w6.
  - The window is zero at reset and at the start of each vector.
- State machine:
  - LOAD: counts accepted samples 0..15. After sample k ≥ 3 is accepted, the window centre holds x_{k−3} and one result is launched. On acceptance of sample 15, go to FLUSH.
  - FLUSH: three automatic zero shifts produce centres x13, x14 and x15. During these shifts busy=1 and in_en is ignored (dropped, not queued). Then return to LOAD with the window cleared.
  - If in_en is sampled high on the same edge that clears the window, that sample is accepted as the new x0 into the zeroed window.
- Gaps: in_en may deassert at any point in LOAD. The window and counters hold, and no results are launched.
- Arithmetic:
  - Accumulator is 38-bit signed; the sum of coefficient magnitudes is 60, so there is no internal overflow.
  - Multiplies are shift-add only.
  - Conversion to integer: add 2^15, then arithmetic shift right by 16 (round half toward +inf).
  - The result is saturated to the range −32768..32767.
- Pipeline: two register stages, window → accumulator register → output register.
- Reset (synchronous, any time, including mid-vector or mid-flush):
  - State returns to LOAD with count 0 and the window zeroed.
  - Accumulator valid bit is cleared.
  - busy=0, out_valid=0, out_last=0, b_out=0 from the cycle after the reset edge.
  - No result from the interrupted vector is ever emitted.

## Timing
- Latency: if x_{i+3} is accepted at edge E, b_i is on b_out with out_valid=1 in the cycle following edge E+2.
- With E15 as the edge that accepts x15:
  - b12 appears after edge E15+2.
  - b13, b14 and b15 appear after edges E15+3, E15+4 and E15+5.
- busy is high in the three cycles following E15. in_en at edges E15+1..E15+3 is ignored, and edge E15+4 accepts normally.
- A contiguous 16-cycle in_en burst yields exactly 16 consecutive out_valid cycles. out_last coincides with b15.
- The maximum back-to-back rate is one vector per 19 cycles: 16 load cycles plus 3 flush cycles.
- out_valid is a single-cycle qualifier per element. There is no backpressure; the consumer must take every element.

## Test plan
- All x_k = 0x00010000 (1.0), contiguous burst → b = 12, −1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, −1, 12.
  - First out_valid appears after edge E3+2; out_last with b15 after edge E15+5.
- Impulse x5 = 0x00010000, all other elements 0 → b2..b8 = −1, 6, −13, 20, −13, 6, −1; all other b = 0.
- Rounding: x0 = 0x00000800, all other elements 0 → b0 = 1 (0.625 rounds up), b1 = 0 (−0.406), b2 = 0, b3 = 0; all other b = 0.
- Saturation:
  - All x = 0x7FFF0000 → b0 = b2 = b3..b12 = b13 = b15 = 32767, b1 = b14 = −32767.
  - Impulse x5 = 0x80000000 → b5 = −32768, b4 = b6 = 32767.
- Gaps, busy drop and back-to-back:
  - Alternate in_en 1/0 for vector 1 → same b values as the first scenario.
  - Assert in_en with junk at edges E15+1..E15+3 → ignored, busy = 1.
  - Vector 2 starting at E15+4 → its b0 appears after edge E15+9, with values uncontaminated by vector 1.
- Reset mid-vector: apply reset after 8 accepted samples → outputs 0 from the next cycle. A following full 1.0 vector gives exactly the first scenario's results with no stale outputs.
